// File: rtl/blackparrot_fpga_host_pkg.sv
// -----------------------------------------------------------------------------
// blackparrot_fpga_host_pkg
//   Shared types and helpers for the BlackParrot FPGA host AXI4-Lite blocks.
//   - arb_state_e   : read-arbiter FSM states
//   - owner_width() : index width for a master count, never less than 1 bit
// -----------------------------------------------------------------------------
package blackparrot_fpga_host_pkg;

    typedef enum logic [1:0] {
        e_arb_idle = 2'd0,
        e_arb_addr = 2'd1,
        e_arb_resp = 2'd2
    } arb_state_e;

    function automatic int unsigned owner_width(input int unsigned num_masters);
        return (num_masters > 1) ? $clog2(num_masters) : 1;
    endfunction

    localparam int unsigned ARB_DEFAULT_MASTERS = 2;
    localparam int unsigned ARB_DEFAULT_OWNER_W = owner_width(ARB_DEFAULT_MASTERS);

endpackage

// File: rtl/blackparrot_fpga_host_axil_read_arbiter_rr.sv
// -----------------------------------------------------------------------------
// bsg_arb_round_robin
//   Combinational round-robin grant over inputs_p requesters. The search
//   starts at an internal pointer; on yumi_i the pointer moves to the slot
//   after the current winner.
// Ports
//   clk_i, rst_ni  clock, asynchronous active-low reset (pointer -> 0)
//   reqs_i         request vector
//   grants_o       one-hot grant (0 when no request)
//   tag_o          index of the granted requester
//   v_o            a grant is being offered
//   yumi_i         consumer accepted the current grant
// -----------------------------------------------------------------------------
module bsg_arb_round_robin
    import blackparrot_fpga_host_pkg::*;
#(
    parameter  int unsigned inputs_p     = 2,
    localparam int unsigned lg_inputs_lp = owner_width(inputs_p)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [inputs_p-1:0]     reqs_i,
    output logic [inputs_p-1:0]     grants_o,
    output logic [lg_inputs_lp-1:0] tag_o,
    output logic                    v_o,
    input  logic                    yumi_i
);

    logic [lg_inputs_lp-1:0] r_ptr;

    always_comb begin
        int unsigned             w_idx;
        logic [lg_inputs_lp-1:0] w_tag;
        logic                    w_found;
        grants_o = '0;
        tag_o    = '0;
        v_o      = 1'b0;
        w_found  = 1'b0;
        w_idx    = 0;
        w_tag    = '0;
        for (int unsigned i = 0; i < inputs_p; i++) begin
            w_idx = (32'(r_ptr) + i) % inputs_p;
            w_tag = lg_inputs_lp'(w_idx);
            if (!w_found && reqs_i[w_tag]) begin
                w_found         = 1'b1;
                v_o             = 1'b1;
                tag_o           = w_tag;
                grants_o[w_tag] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr <= '0;
        end else if (yumi_i && v_o) begin
            r_ptr <= (32'(tag_o) == inputs_p - 1) ? '0 : tag_o + lg_inputs_lp'(1);
        end
    end

endmodule

// File: rtl/blackparrot_fpga_host_axil_read_arbiter.sv
// -----------------------------------------------------------------------------
// blackparrot_fpga_host_axil_read_arbiter
//   Shares one AXI4-Lite read port among NUM_MASTERS_P read masters with
//   round-robin grant and a single read outstanding system-wide. The response
//   is routed only to the master that issued the read.
// Ports
//   s_axil_aclk / s_axil_aresetn   clock, asynchronous active-low reset
//   s_axil_ar*  (N-wide, packed)   per-master read address channel
//   s_axil_r*   (N-wide, packed)   per-master read data channel
//   m_axil_ar*                     downstream read address channel
//   m_axil_r*                      downstream read data channel
// -----------------------------------------------------------------------------
module blackparrot_fpga_host_axil_read_arbiter
    import blackparrot_fpga_host_pkg::*;
#(
    parameter int unsigned NUM_MASTERS_P     = 2,
    parameter int unsigned S_AXIL_ADDR_WIDTH = 64,
    parameter int unsigned S_AXIL_DATA_WIDTH = 32
) (
    input  logic                                       s_axil_aclk,
    input  logic                                       s_axil_aresetn,

    input  logic [NUM_MASTERS_P*S_AXIL_ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [NUM_MASTERS_P*3-1:0]                 s_axil_arprot,
    input  logic [NUM_MASTERS_P-1:0]                   s_axil_arvalid,
    output logic [NUM_MASTERS_P-1:0]                   s_axil_arready,
    output logic [NUM_MASTERS_P*S_AXIL_DATA_WIDTH-1:0] s_axil_rdata,
    output logic [NUM_MASTERS_P*2-1:0]                 s_axil_rresp,
    output logic [NUM_MASTERS_P-1:0]                   s_axil_rvalid,
    input  logic [NUM_MASTERS_P-1:0]                   s_axil_rready,

    output logic [S_AXIL_ADDR_WIDTH-1:0]               m_axil_araddr,
    output logic [2:0]                                 m_axil_arprot,
    output logic                                       m_axil_arvalid,
    input  logic                                       m_axil_arready,
    input  logic [S_AXIL_DATA_WIDTH-1:0]               m_axil_rdata,
    input  logic [1:0]                                 m_axil_rresp,
    input  logic                                       m_axil_rvalid,
    output logic                                       m_axil_rready
);

    localparam int unsigned N  = NUM_MASTERS_P;
    localparam int unsigned AW = S_AXIL_ADDR_WIDTH;
    localparam int unsigned DW = S_AXIL_DATA_WIDTH;
    localparam int unsigned OW = owner_width(N);

    arb_state_e    r_state;
    arb_state_e    w_state_nxt;
    logic [AW-1:0] r_addr;
    logic [2:0]    r_prot;
    logic [OW-1:0] r_owner;

    logic [N-1:0]  w_grants;
    logic [OW-1:0] w_grant_tag;
    logic          w_grant_v;
    logic          w_accept;
    logic          w_r_hs;

    // The arbiter pointer advances at grant rather than at the R handshake.
    // With one read in flight the pointer is only consulted in IDLE, so both
    // choices yield the same grant sequence.
    bsg_arb_round_robin #(
        .inputs_p (N)
    ) u_rr (
        .clk_i    (s_axil_aclk),
        .rst_ni   (s_axil_aresetn),
        .reqs_i   (s_axil_arvalid),
        .grants_o (w_grants),
        .tag_o    (w_grant_tag),
        .v_o      (w_grant_v),
        .yumi_i   (w_accept)
    );

    // arready is combinational on arvalid; gating with reset keeps every
    // output low while aresetn is held, even if masters keep requesting.
    assign w_accept = (r_state == e_arb_idle) && w_grant_v && s_axil_aresetn;
    assign w_r_hs   = (r_state == e_arb_resp) && m_axil_rvalid && s_axil_rready[r_owner];

    always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
        if (!s_axil_aresetn) begin
            r_state <= e_arb_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            e_arb_idle: if (w_accept)       w_state_nxt = e_arb_addr;
            e_arb_addr: if (m_axil_arready) w_state_nxt = e_arb_resp;
            e_arb_resp: if (w_r_hs)         w_state_nxt = e_arb_idle;
            default:                        w_state_nxt = e_arb_idle;
        endcase
    end

    always_ff @(posedge s_axil_aclk or negedge s_axil_aresetn) begin
        if (!s_axil_aresetn) begin
            r_addr  <= '0;
            r_prot  <= '0;
            r_owner <= '0;
        end else if (w_accept) begin
            r_addr  <= s_axil_araddr[32'(w_grant_tag)*AW +: AW];
            r_prot  <= s_axil_arprot[32'(w_grant_tag)*3 +: 3];
            r_owner <= w_grant_tag;
        end
    end

    always_comb begin
        s_axil_arready = '0;
        s_axil_rdata   = '0;
        s_axil_rresp   = '0;
        s_axil_rvalid  = '0;
        m_axil_araddr  = '0;
        m_axil_arprot  = '0;
        m_axil_arvalid = 1'b0;
        m_axil_rready  = 1'b0;
        case (r_state)
            e_arb_idle: begin
                if (w_accept) begin
                    s_axil_arready = w_grants;
                end
            end
            e_arb_addr: begin
                m_axil_arvalid = 1'b1;
                m_axil_araddr  = r_addr;
                m_axil_arprot  = r_prot;
            end
            e_arb_resp: begin
                s_axil_rvalid[r_owner]                 = m_axil_rvalid;
                s_axil_rdata[32'(r_owner)*DW +: DW]    = m_axil_rdata;
                s_axil_rresp[32'(r_owner)*2 +: 2]      = m_axil_rresp;
                m_axil_rready                          = s_axil_rready[r_owner];
            end
            default: ;
        endcase
    end

endmodule
